// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, addressing modes, IR field positions and
// the fetch state encoding used by fetch_unit.
package cpu_pkg;

    localparam logic [3:0] OP_NOOP = 4'd0;
    localparam logic [3:0] OP_LOD  = 4'd1;
    localparam logic [3:0] OP_STR  = 4'd2;
    localparam logic [3:0] OP_BRA  = 4'd4;
    localparam logic [3:0] OP_BRR  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;
    localparam logic [3:0] OP_ALU  = 4'd8;
    localparam logic [3:0] OP_HLT  = 4'd15;

    localparam logic [3:0] AM_IMM  = 4'd1;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 28;
    localparam int MM_HI  = 27;
    localparam int MM_LO  = 24;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    function automatic logic [3:0] ir_opcode(input logic [31:0] ir);
        return ir[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/fetch_branch_calc.sv
// Combinational branch resolver: decides whether the instruction in IR
// redirects the PC and computes the redirect target.
module fetch_branch_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [3:0]        i_opcode,
    input  logic [3:0]        i_mm,
    input  logic [15:0]       i_imm,
    input  logic [3:0]        i_stat,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_taken,
    output logic [ADDR_W-1:0] o_target
);

    localparam int EXT_W = (ADDR_W > 16) ? ADDR_W : 16;

    logic [EXT_W-1:0] w_imm_sext;
    logic [EXT_W-1:0] w_imm_zext;

    assign w_imm_sext = EXT_W'($signed(i_imm));
    assign w_imm_zext = EXT_W'(i_imm);

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        o_taken  = 1'b0;
        o_target = i_pc;
        case (i_opcode)
            OP_BRA: begin
                o_taken  = 1'b1;
                o_target = w_imm_zext[ADDR_W-1:0];
            end
            OP_BRR: begin
                // PC already points past the branch, so the base is PC-1.
                o_taken  = 1'b1;
                o_target = i_pc - ADDR_W'(1) + w_imm_sext[ADDR_W-1:0];
            end
            OP_BNE: begin
                o_taken  = |(i_stat & i_mm);
                o_target = w_imm_zext[ADDR_W-1:0];
            end
            default: begin
                o_taken  = 1'b0;
                o_target = i_pc;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and IR, fetches over a req/ack port and
// applies branch redirects. Optional fetch timeout: define FETCH_TIMEOUT_EN.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int RESET_PC    = 0,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pc_write,
    input  logic              i_br_sel,
    input  logic              i_pc_sel,
    input  logic [3:0]        i_stat,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [31:0]       i_imem_data,
    output logic [3:0]        o_opcode,
    output logic [3:0]        o_mm,
    output logic [15:0]       o_imm,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_ir_valid,
    output logic              o_fetch_busy,
    output logic              o_halted,
    output logic              o_fetch_err
);

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir;
    logic              r_imem_req;
    logic              r_ir_valid;
    logic              r_busy;
    logic              r_halted;
    logic              r_pc_write_q;
    logic              r_pc_sel_q;
    logic              r_br_pend;
    logic              r_def_pend;
    logic              r_def_taken;
    logic [ADDR_W-1:0] r_def_target;

    logic              w_pc_write_edge;
    logic              w_branch_go;
    logic              w_taken;
    logic [ADDR_W-1:0] w_target;
    logic              w_unused_ir;

    assign w_pc_write_edge = i_pc_write & ~r_pc_write_q;
    assign w_branch_go     = i_pc_sel & ~r_pc_sel_q & r_br_pend;
    assign w_unused_ir     = ^r_ir[23:16];

    fetch_branch_calc #(
        .ADDR_W (ADDR_W)
    ) u_branch_calc (
        .i_opcode (r_ir[OPC_HI:OPC_LO]),
        .i_mm     (r_ir[MM_HI:MM_LO]),
        .i_imm    (r_ir[IMM_HI:IMM_LO]),
        .i_stat   (i_stat),
        .i_pc     (r_pc),
        .o_taken  (w_taken),
        .o_target (w_target)
    );

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] r_wait;
    logic       r_err;
    assign o_fetch_err = r_err;
`else
    logic [3:0] w_unused_timeout;
    assign w_unused_timeout = 4'(TIMEOUT_CYC);
    assign o_fetch_err      = 1'b0;
`endif

    // NOTE: all state below updates with <= so every register sees pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_pc         <= ADDR_W'(RESET_PC);
            r_ir         <= {OP_NOOP, 28'd0};
            r_imem_req   <= 1'b0;
            r_ir_valid   <= 1'b0;
            r_busy       <= 1'b0;
            r_halted     <= 1'b0;
            r_pc_write_q <= 1'b0;
            r_pc_sel_q   <= 1'b0;
            r_br_pend    <= 1'b0;
            r_def_pend   <= 1'b0;
            r_def_taken  <= 1'b0;
            r_def_target <= ADDR_W'(RESET_PC);
`ifdef FETCH_TIMEOUT_EN
            r_wait       <= 4'd0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_pc_write_q <= i_pc_write;
            r_pc_sel_q   <= i_pc_sel;

            if (w_branch_go) r_br_pend <= 1'b0;
            if (i_br_sel)    r_br_pend <= 1'b1;

            // Outside REQ a redirect hits PC now; a recorded one lands after the fetch.
            if (r_state != ST_REQ) begin
                if (w_branch_go) begin
                    if (w_taken) r_pc <= w_target;
                end else if (r_def_pend && r_def_taken) begin
                    r_pc <= r_def_target;
                end
                r_def_pend <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_pc_write_edge) begin
                        r_state    <= ST_REQ;
                        r_imem_req <= 1'b1;
                        r_busy     <= 1'b1;
                        r_ir_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                        r_wait     <= 4'd0;
`endif
                    end
                end
                ST_REQ: begin
                    if (w_branch_go) begin
                        r_def_pend   <= 1'b1;
                        r_def_taken  <= w_taken;
                        r_def_target <= w_target;
                    end
                    if (i_imem_ack) begin
                        r_ir       <= i_imem_data;
                        r_pc       <= r_pc + ADDR_W'(1);
                        r_imem_req <= 1'b0;
                        r_busy     <= 1'b0;
                        r_ir_valid <= 1'b1;
                        if (ir_opcode(i_imem_data) == OP_HLT) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_state  <= ST_IDLE;
                        end
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (r_wait == 4'(TIMEOUT_CYC - 1)) begin
                        r_ir       <= {OP_NOOP, 28'd0};
                        r_pc       <= r_pc + ADDR_W'(1);
                        r_err      <= 1'b1;
                        r_imem_req <= 1'b0;
                        r_busy     <= 1'b0;
                        r_ir_valid <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
`endif
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_imem_req   = r_imem_req;
    assign o_imem_addr  = r_pc;
    assign o_pc         = r_pc;
    assign o_opcode     = r_ir[OPC_HI:OPC_LO];
    assign o_mm         = r_ir[MM_HI:MM_LO];
    assign o_imm        = r_ir[IMM_HI:IMM_LO];
    assign o_ir_valid   = r_ir_valid;
    assign o_fetch_busy = r_busy;
    assign o_halted     = r_halted;

endmodule
